// File: rtl/cnn_layer_accel_pixel_fetch_pkg.sv
// rtl/cnn_layer_accel_pixel_fetch_pkg.sv - shared definitions for the CNN layer pixel fetch block
//
// Contents:
//   PIXEL_WORD_WIDTH  width of one memory word / pixel beat (8 depth-slices of one pixel)
//   DIM_WIDTH         width of the row/column counts of the input map
//   dim_t             row/column count type
//   fetch_state_t     pixel fetch FSM state encoding
//   fifo_cnt_width()  occupancy counter width for a FIFO of a given depth
package cnn_layer_accel_pixel_fetch_pkg;

  localparam int PIXEL_WORD_WIDTH = 128;
  localparam int DIM_WIDTH        = 10;

  typedef logic [DIM_WIDTH-1:0] dim_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACK      = 3'd1,
    ST_STREAM   = 3'd2,
    ST_COMPLETE = 3'd3,
    ST_DONE     = 3'd4
  } fetch_state_t;

  // An occupancy counter must be able to hold the value DEPTH itself.
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_fetch_fifo.sv
// rtl/cnn_layer_accel_fetch_fifo.sv - single-clock first-word-fall-through read-data buffer
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset, empties the buffer
//   wr_en    in   write strobe (ignored when full)
//   wr_data  in   WIDTH  word to store
//   rd_en    in   pop strobe (ignored when empty)
//   rd_data  out  WIDTH  head word, valid whenever count != 0
//   count    out  number of stored words (0..DEPTH)
module cnn_layer_accel_fetch_fifo
  import cnn_layer_accel_pixel_fetch_pkg::*;
#(
  parameter  int WIDTH = PIXEL_WORD_WIDTH,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = fifo_cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && (count != CNT_W'(DEPTH));
  assign do_rd = rd_en && (count != '0);

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  // Storage carries no reset; stale contents are never visible because
  // the consumer only looks at rd_data while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/cnn_layer_accel_pixel_fetch.sv
// rtl/cnn_layer_accel_pixel_fetch.sv - row-by-row pixel fetcher feeding a compute quad
//
// Ports:
//   clk_if              in   sole clock, rising edge
//   rst                 in   asynchronous active-high reset
//   cfg_load            in   strobe capturing cfg_num_rows/cfg_num_cols/cfg_base_addr
//   cfg_num_rows        in   10  input-map rows
//   cfg_num_cols        in   10  input-map columns (pixels per row)
//   cfg_base_addr       in   ADDR_WIDTH  word address of pixel 0
//   job_fetch_request   in   quad asks for the next row
//   job_fetch_ack       out  one-cycle grant of a row fetch
//   job_fetch_complete  out  one-cycle pulse after the last pixel of a row is taken
//   pixel_valid/ready/data     pixel stream to the quad (128-bit beats)
//   mem_rd_req/ready/addr      read request port, accepted on req & ready
//   mem_rd_valid/data          in-order, unthrottled read return
//   fetch_done          out  level, every configured row has been delivered
module cnn_layer_accel_pixel_fetch
  import cnn_layer_accel_pixel_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_if,
  input  logic                        rst,
  input  logic                        cfg_load,
  input  logic [DIM_WIDTH-1:0]        cfg_num_rows,
  input  logic [DIM_WIDTH-1:0]        cfg_num_cols,
  input  logic [ADDR_WIDTH-1:0]       cfg_base_addr,
  input  logic                        job_fetch_request,
  output logic                        job_fetch_ack,
  output logic                        job_fetch_complete,
  output logic                        pixel_valid,
  input  logic                        pixel_ready,
  output logic [PIXEL_WORD_WIDTH-1:0] pixel_data,
  output logic                        mem_rd_req,
  input  logic                        mem_rd_ready,
  output logic [ADDR_WIDTH-1:0]       mem_rd_addr,
  input  logic                        mem_rd_valid,
  input  logic [PIXEL_WORD_WIDTH-1:0] mem_rd_data,
  output logic                        fetch_done
);

  localparam int CNT_W = fifo_cnt_width(FIFO_DEPTH);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] CREDIT_LIMIT = SUM_W'(FIFO_DEPTH);

  fetch_state_t                state;
  dim_t                        num_rows;
  dim_t                        num_cols;
  dim_t                        row_cnt;
  dim_t                        row_next;
  dim_t                        req_cnt;
  dim_t                        out_cnt;
  logic [ADDR_WIDTH-1:0]       rd_addr;
  logic [CNT_W-1:0]            outstanding;
  logic [CNT_W-1:0]            fifo_count;
  logic [PIXEL_WORD_WIDTH-1:0] fifo_head;
  logic [SUM_W-1:0]            in_flight;
  logic                        ack_q;
  logic                        complete_q;
  logic                        done_q;
  logic                        in_stream;
  logic                        credit_ok;
  logic                        req_fire;
  logic                        rd_accept;
  logic                        pop;
  logic                        last_pixel;

  assign in_stream = (state == ST_STREAM);
  assign row_next  = row_cnt + 1'b1;

  // Every word in flight or buffered holds a FIFO slot, so a return can
  // never find the buffer full.
  assign in_flight = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok = (in_flight < CREDIT_LIMIT);

  assign mem_rd_req = in_stream && (req_cnt < num_cols) && credit_ok;
  assign req_fire   = mem_rd_req && mem_rd_ready;

  // A return only counts against a request issued in this row; anything
  // arriving with nothing outstanding is left over from before a reset.
  assign rd_accept = in_stream && mem_rd_valid && (outstanding != '0);

  assign pixel_valid = in_stream && (fifo_count != '0);
  assign pixel_data  = pixel_valid ? fifo_head : '0;
  assign pop         = pixel_valid && pixel_ready;
  assign last_pixel  = (out_cnt == num_cols - 1'b1);

  assign mem_rd_addr        = rd_addr;
  assign job_fetch_ack      = ack_q;
  assign job_fetch_complete = complete_q;
  assign fetch_done         = done_q;

  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      num_rows    <= '0;
      num_cols    <= '0;
      row_cnt     <= '0;
      req_cnt     <= '0;
      out_cnt     <= '0;
      rd_addr     <= '0;
      outstanding <= '0;
      ack_q       <= 1'b0;
      complete_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ack_q       <= 1'b0;
      complete_q  <= 1'b0;
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rd_accept);

      // Address runs on across rows and wraps at the top of the space.
      if (req_fire) begin
        rd_addr <= rd_addr + 1'b1;
        req_cnt <= req_cnt + 1'b1;
      end
      if (pop) begin
        out_cnt <= out_cnt + 1'b1;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (cfg_load) begin
            num_rows <= cfg_num_rows;
            num_cols <= cfg_num_cols;
            rd_addr  <= cfg_base_addr;
            row_cnt  <= '0;
            done_q   <= 1'b0;
            state    <= ST_IDLE;
          end else if ((state == ST_IDLE) && job_fetch_request &&
                       (row_cnt < num_rows)) begin
            state <= ST_ACK;
            ack_q <= 1'b1;
          end
        end

        ST_ACK: begin
          req_cnt <= '0;
          out_cnt <= '0;
          state   <= ST_STREAM;
        end

        ST_STREAM: begin
          if (pop && last_pixel) begin
            state      <= ST_COMPLETE;
            complete_q <= 1'b1;
          end
        end

        ST_COMPLETE: begin
          row_cnt <= row_next;
          if (row_next == num_rows) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  cnn_layer_accel_fetch_fifo #(
    .WIDTH (PIXEL_WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_if),
    .rst     (rst),
    .wr_en   (rd_accept),
    .wr_data (mem_rd_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_cnn_layer_accel_pixel_fetch.sv
// tb/tb_cnn_layer_accel_pixel_fetch.sv - randomized self-checking bench for the pixel fetch block
module tb_cnn_layer_accel_pixel_fetch;

  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic           clk_if = 1'b0;
  logic           rst;
  logic           cfg_load;
  logic [9:0]     cfg_num_rows;
  logic [9:0]     cfg_num_cols;
  logic [AW-1:0]  cfg_base_addr;
  logic           job_fetch_request;
  logic           job_fetch_ack;
  logic           job_fetch_complete;
  logic           pixel_valid;
  logic           pixel_ready;
  logic [127:0]   pixel_data;
  logic           mem_rd_req;
  logic           mem_rd_ready;
  logic [AW-1:0]  mem_rd_addr;
  logic           mem_rd_valid;
  logic [127:0]   mem_rd_data;
  logic           fetch_done;

  always #5 clk_if = ~clk_if;

  cnn_layer_accel_pixel_fetch #(
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_if             (clk_if),
    .rst                (rst),
    .cfg_load           (cfg_load),
    .cfg_num_rows       (cfg_num_rows),
    .cfg_num_cols       (cfg_num_cols),
    .cfg_base_addr      (cfg_base_addr),
    .job_fetch_request  (job_fetch_request),
    .job_fetch_ack      (job_fetch_ack),
    .job_fetch_complete (job_fetch_complete),
    .pixel_valid        (pixel_valid),
    .pixel_ready        (pixel_ready),
    .pixel_data         (pixel_data),
    .mem_rd_req         (mem_rd_req),
    .mem_rd_ready       (mem_rd_ready),
    .mem_rd_addr        (mem_rd_addr),
    .mem_rd_valid       (mem_rd_valid),
    .mem_rd_data        (mem_rd_data),
    .fetch_done         (fetch_done)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } rd_t;

  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            lat      = 3;
  rd_t           mq[$];
  rd_t           mon_e;
  logic [127:0]  got[$];
  int            n_ack, n_cmp, stab_err, addr_err, credit_err, gap_err;
  int            fired, popped;
  int            cmp_cyc  = -1;
  bit            stalled_pix, stalled_req;
  logic [127:0]  held_pix;
  logic [AW-1:0] held_addr;
  logic [AW-1:0] b, b2;
  logic [9:0]    rr, cc;

  // Memory contents: a fixed function of the word address.
  function automatic logic [127:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 32'hA5A5_0F0F, a * 32'h9E37_79B9, ~a, a};
  endfunction

  initial forever begin
    @(posedge clk_if);
    cyc++;
  end

  // Memory responder: returns each accepted read exactly lat cycles later, in order.
  // It deliberately keeps delivering across a reset.
  initial begin
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(posedge clk_if);
      #1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
      end
    end
  end

  // Observer on the falling edge: collects pixels and protocol statistics.
  initial forever begin
    @(negedge clk_if);
    if (rst) begin
      fired       = 0;
      popped      = 0;
      stalled_pix = 1'b0;
      stalled_req = 1'b0;
      cmp_cyc     = -1;
    end else begin
      if (stalled_pix && !(pixel_valid && pixel_data === held_pix)) stab_err++;
      if (stalled_req && !(mem_rd_req && mem_rd_addr === held_addr)) addr_err++;
      stalled_pix = pixel_valid && !pixel_ready;
      held_pix    = pixel_data;
      stalled_req = mem_rd_req && !mem_rd_ready;
      held_addr   = mem_rd_addr;
      if (pixel_valid && pixel_ready) begin
        got.push_back(pixel_data);
        popped++;
      end
      if (mem_rd_req && mem_rd_ready) begin
        fired++;
        mon_e.addr = mem_rd_addr;
        mon_e.due  = cyc + lat;
        mq.push_back(mon_e);
      end
      if (fired - popped > DEPTH) credit_err++;
      if (job_fetch_complete) begin
        n_cmp++;
        cmp_cyc = cyc;
      end
      if (job_fetch_ack) begin
        n_ack++;
        if (cmp_cyc >= 0 && (cyc - cmp_cyc) != 2) gap_err++;
        cmp_cyc = -1;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    got.delete();
    n_ack = 0; n_cmp = 0; stab_err = 0; addr_err = 0; credit_err = 0; gap_err = 0;
    fired = 0; popped = 0; cmp_cyc = -1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"},      128'(job_fetch_ack), 128'(0));
    check({tag, "_complete"}, 128'(job_fetch_complete), 128'(0));
    check({tag, "_pvalid"},   128'(pixel_valid), 128'(0));
    check({tag, "_memreq"},   128'(mem_rd_req), 128'(0));
    check({tag, "_done"},     128'(fetch_done), 128'(0));
    check({tag, "_pdata"},    pixel_data, 128'(0));
    check({tag, "_memaddr"},  128'(mem_rd_addr), 128'(0));
  endtask

  task automatic do_cfg(input logic [9:0] r, input logic [9:0] c, input logic [AW-1:0] base);
    @(posedge clk_if);
    #1;
    cfg_load      = 1'b1;
    cfg_num_rows  = r;
    cfg_num_cols  = c;
    cfg_base_addr = base;
    @(posedge clk_if);
    #1;
    cfg_load = 1'b0;
  endtask

  // pr_mode: 0 always ready, 1 toggle, 2 random.
  // mr_mode: 0 always ready, 1 random, 2 one 20-cycle stall once 3 pixels are out.
  // stop_pix < 0 runs to fetch_done, otherwise stops once that many pixels are taken.
  task automatic run_fetch(input int pr_mode, input int mr_mode, input int stop_pix, input int budget);
    int  stall_left = 20;
    bit  reached    = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk_if);
      #1;
      job_fetch_request = 1'b1;
      case (pr_mode)
        0:       pixel_ready = 1'b1;
        1:       pixel_ready = ~pixel_ready;
        default: pixel_ready = 1'($urandom_range(0, 1));
      endcase
      case (mr_mode)
        0:       mem_rd_ready = 1'b1;
        1:       mem_rd_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (got.size() >= 3 && stall_left > 0) begin
            mem_rd_ready = 1'b0;
            stall_left--;
          end else begin
            mem_rd_ready = 1'b1;
          end
        end
      endcase
      if (stop_pix >= 0 ? (got.size() >= stop_pix) : (fetch_done === 1'b1)) begin
        reached = 1'b1;
        break;
      end
    end
    check("run_reached_goal", 128'(reached), 128'(1));
  endtask

  // Reference: R*C consecutive words from base, R grants, R completions, done.
  task automatic check_fetch(input int r, input int c, input logic [AW-1:0] base, input string tag);
    check({tag, "_pixel_count"}, 128'(got.size()), 128'(r * c));
    for (int i = 0; i < r * c && i < got.size(); i++) begin
      check({tag, "_pixel"}, got[i], mem_word(base + AW'(i)));
    end
    check({tag, "_acks"},        128'(n_ack), 128'(r));
    check({tag, "_completes"},   128'(n_cmp), 128'(r));
    check({tag, "_fetch_done"},  128'(fetch_done), 128'(1));
    check({tag, "_stable"},      128'(stab_err), 128'(0));
    check({tag, "_addr_held"},   128'(addr_err), 128'(0));
    check({tag, "_credit"},      128'(credit_err), 128'(0));
    check({tag, "_ack_gap"},     128'(gap_err), 128'(0));
  endtask

  initial begin
    rst               = 1'b1;
    cfg_load          = 1'b0;
    cfg_num_rows      = '0;
    cfg_num_cols      = '0;
    cfg_base_addr     = '0;
    job_fetch_request = 1'b0;
    pixel_ready       = 1'b0;
    mem_rd_ready      = 1'b0;
    clear_stats();

    // Reset state, then no fetch before any configuration.
    repeat (3) @(posedge clk_if);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    job_fetch_request = 1'b1;
    repeat (6) @(posedge clk_if);
    #1;
    check("no_ack_before_cfg", 128'(n_ack), 128'(0));
    check("no_memreq_before_cfg", 128'(mem_rd_req), 128'(0));

    // 10x10 map from 0x100, everything ready, latency 3.
    lat = 3;
    clear_stats();
    do_cfg(10'd10, 10'd10, 32'h100);
    run_fetch(0, 0, -1, 4000);
    check_fetch(10, 10, 32'h100, "map10x10");
    repeat (10) @(posedge clk_if);
    #1;
    check("no_ack_in_done", 128'(n_ack), 128'(10));
    check("done_level_held", 128'(fetch_done), 128'(1));

    // Consumer toggling ready every cycle.
    b = $urandom;
    clear_stats();
    do_cfg(10'd3, 10'd10, b);
    run_fetch(1, 0, -1, 4000);
    check_fetch(3, 10, b, "toggle_ready");

    // Memory refuses requests for 20 cycles mid-row.
    b = $urandom;
    clear_stats();
    do_cfg(10'd2, 10'd10, b);
    run_fetch(0, 2, -1, 4000);
    check_fetch(2, 10, b, "mem_stall");

    // Reset in the middle of row 3, then a fresh small job.
    b = $urandom;
    clear_stats();
    do_cfg(10'd5, 10'd10, b);
    run_fetch(0, 0, 35, 4000);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrow_rst");
    repeat (2) @(posedge clk_if);
    #1;
    rst = 1'b0;
    clear_stats();
    repeat (6) @(posedge clk_if);
    #1;
    check("post_rst_no_ack", 128'(n_ack), 128'(0));
    check("post_rst_no_pixels", 128'(got.size()), 128'(0));
    b2 = $urandom;
    clear_stats();
    do_cfg(10'd2, 10'd4, b2);
    run_fetch(2, 1, -1, 4000);
    check_fetch(2, 4, b2, "after_rst");

    // cfg_load while streaming must be ignored.
    b = $urandom;
    clear_stats();
    do_cfg(10'd2, 10'd6, b);
    run_fetch(0, 0, 1, 4000);
    cfg_load      = 1'b1;
    cfg_num_rows  = 10'd7;
    cfg_num_cols  = 10'd3;
    cfg_base_addr = b ^ 32'h0000_FFFF;
    @(posedge clk_if);
    #1;
    cfg_load = 1'b0;
    run_fetch(0, 0, -1, 4000);
    check_fetch(2, 6, b, "cfg_in_stream");

    // Randomized shapes, latencies and handshake behaviour; first one wraps the address space.
    for (int t = 0; t < 5; t++) begin
      rr  = 10'($urandom_range(1, 4));
      cc  = 10'($urandom_range(1, 12));
      b   = (t == 0) ? 32'hFFFF_FFFC : $urandom;
      lat = int'($urandom_range(1, 6));
      clear_stats();
      do_cfg(rr, cc, b);
      run_fetch(int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), -1, 6000);
      check_fetch(int'(rr), int'(cc), b, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
